comet_ii_mem_responder: RTL and testbench
=========================================

# comet_ii_mem_responder

Word-addressed memory responder for the COMET II CPU. It sits on the other side of the controller's memory port: it accepts the 16-bit `adr` / `adr_en` request and the store data, inserts a programmable number of wait states, then returns `rdata` with a one-cycle `ready` pulse. It holds the program and data store that the controller fetches from, loads from, stores to, and pushes/pops against.

## Interface
- `ADR_W`, 12, number of implemented address bits; depth is 2**ADR_W 16-bit words.
- `WAIT_STATES`, 1, extra cycles inserted before `ready`; legal range 0..15.
- `mclk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `adr` in 16: word address, qualified by `adr_en`.
- `adr_en` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = read; sampled with `adr_en`.
- `wdata` in 16: store data; sampled with `adr_en`.
- `rdata` out 16: read data, or echoed store data; valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high in WAIT and RESP.
- `err` out 1: access out of range; valid with `ready`.

## Operation
- States are IDLE, WAIT and RESP, held in a 2-bit register. A 4-bit `cnt` counts wait states.
- **IDLE:**
  - On an edge with `adr_en`=1, latch `adr`, `we` and `wdata`.
  - Go to WAIT with `cnt`=WAIT_STATES-1, or go straight to RESP when WAIT_STATES=0.
  - With `adr_en`=0, stay in IDLE.
- **WAIT:**
  - If `cnt`≠0, decrement `cnt` each edge.
  - On the edge where `cnt`=0, go to RESP.
  - `adr_en` is ignored. Aborts are not supported: a request latched in IDLE always completes.
- **Entering RESP:**
  - Read: `rdata` ← mem[latched adr[ADR_W-1:0]].
  - Write: mem ← latched `wdata`, and `rdata` ← latched `wdata`.
- **RESP:**
  - Lasts exactly one cycle with `ready`=1, then unconditionally returns to IDLE.
  - At least one IDLE cycle separates consecutive transactions.
- The memory array is not reset. Its contents survive `rst`. Simulation initial contents are all zero.
- Arithmetic: `cnt` is 4-bit unsigned. Address bits above ADR_W are handled as described under Configuration.

## Timing
- Reset values: state=IDLE, `cnt`=0, `rdata`=16'h0000, `ready`=0, `busy`=0, `err`=0.
- Request sampled at edge E. `ready`=1 during the cycle after edge E+WAIT_STATES, which is WAIT_STATES+1 cycles after E. With WAIT_STATES=0, `ready` is high in the cycle after E.
- `busy` rises in the cycle after E and falls together with `ready`.
- `rdata` is registered. It is updated only on the edge entering RESP and holds its value afterwards until the next transaction.
- `adr_en` held high through the RESP cycle is resampled in IDLE on the following edge, giving a back-to-back request.
- `rst` asserted mid-transaction: state returns to IDLE immediately (asynchronously).
  - A pending write that has not yet reached the RESP-entry edge is dropped.
  - No `ready` pulse is produced for that request.

## Configuration
- Macro: `COMET_II_MEM_BOUNDS_CHECK_EN`.
- **Defined:**
  - A latched address with any bit of adr[15:ADR_W] set is out of range.
  - On entering RESP for such an access: `err`=1 alongside `ready`, read returns 16'h0000, and the write is discarded with memory unchanged.
  - When ADR_W=16, no address is out of range.
- **Undefined:**
  - The address wraps modulo 2**ADR_W, using only the low ADR_W bits.
  - `err` is tied to 0.

## Test plan
- Reset, then write adr=16'h0010, wdata=16'hBEEF with WAIT_STATES=1 -> `ready` is high in the 2nd cycle after the sampling edge, `rdata`=16'hBEEF. A later read of 16'h0010 returns 16'hBEEF.
- WAIT_STATES=0, back-to-back reads of 16'h0010 and 16'h0011 with `adr_en` held high -> `ready` pulses 2 cycles apart, `busy` drops for exactly one IDLE cycle between them.
- `adr_en` drops during WAIT with WAIT_STATES=3 -> `ready` still pulses once, 4 cycles after the sampling edge, with the correct data.
- `rst` asserted during WAIT of a write to 16'h0020 -> outputs return to reset values immediately and no `ready` pulse follows. A subsequent read of 16'h0020 returns the prior contents. Memory at 16'h0010 is still 16'hBEEF.
- ADR_W=12, write 16'h1234 to adr=16'h1005:
  - With `COMET_II_MEM_BOUNDS_CHECK_EN` -> `err`=1 with `ready`, and mem[16'h005] is unchanged.
  - Without it -> `err`=0, and mem[16'h005]=16'h1234.

Source files
------------

// File: rtl/comet_ii_mem_responder_if.sv
// Memory-port bundle between the COMET II controller (master) and the
// memory responder (slave).
interface comet_ii_mem_responder_if;
  logic [15:0] adr;
  logic        adr_en;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output adr, adr_en, we, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  adr, adr_en, we, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/comet_ii_mem_responder.sv
// Word-addressed memory responder for the COMET II controller.
// Accepts one request in IDLE, waits WAIT_STATES cycles, then answers with a
// one-cycle ready pulse carrying read data or the echoed store data.
// Optional feature macro: COMET_II_MEM_BOUNDS_CHECK_EN flags addresses with
// bits set above ADR_W (err=1, read returns zero, store dropped); without it
// the address wraps and err stays low.
module comet_ii_mem_responder #(
  parameter int unsigned ADR_W       = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                      mclk,
  input logic                      rst,
  comet_ii_mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 32'd1 << ADR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] adr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        ready_q;
  logic        busy_q;
  logic        err_q;

  logic [15:0] mem [DEPTH];

  logic [15:0]      acc_adr_c;
  logic             acc_we_c;
  logic [15:0]      acc_wdata_c;
  logic [ADR_W-1:0] acc_idx_c;
  logic             enter_resp_c;
  logic             oor_c;

  // With zero wait states the access completes on the sampling edge itself,
  // so the live bus fields are used instead of the latched copies.
  assign acc_adr_c   = (state_q == S_IDLE) ? bus.adr   : adr_q;
  assign acc_we_c    = (state_q == S_IDLE) ? bus.we    : we_q;
  assign acc_wdata_c = (state_q == S_IDLE) ? bus.wdata : wdata_q;
  assign acc_idx_c   = acc_adr_c[ADR_W-1:0];

  // Edge on which the FSM moves into RESP and the memory is accessed.
  assign enter_resp_c = ((state_q == S_IDLE) && bus.adr_en && (WAIT_STATES == 0))
                     || ((state_q == S_WAIT) && (cnt_q == 4'd0));

`ifdef COMET_II_MEM_BOUNDS_CHECK_EN
  // Mask of address bits beyond the implemented depth; empty when ADR_W=16.
  localparam logic [15:0] HI_MASK = 16'(~((32'd1 << ADR_W) - 32'd1));
  assign oor_c = |(acc_adr_c & HI_MASK);
`else
  logic unused_hi_c;
  assign unused_hi_c = ^acc_adr_c;
  assign oor_c       = 1'b0;
`endif

  // Storage array: written only on RESP entry, never reset.
  always_ff @(posedge mclk) begin
    if (enter_resp_c && acc_we_c && !oor_c && !rst) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_resp_c) begin
        state_q <= S_RESP;
        ready_q <= 1'b1;
        busy_q  <= 1'b1;
        err_q   <= oor_c;
        if (acc_we_c) begin
          rdata_q <= acc_wdata_c;
        end else if (oor_c) begin
          rdata_q <= 16'h0000;
        end else begin
          rdata_q <= mem[acc_idx_c];
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.adr_en) begin
              adr_q   <= bus.adr;
              we_q    <= bus.we;
              wdata_q <= bus.wdata;
              cnt_q   <= 4'(WAIT_STATES - 32'd1);
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
          end
          S_RESP: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_comet_ii_mem_responder.sv
// Directed bench for comet_ii_mem_responder: three instances with
// WAIT_STATES = 0, 1 and 3 share address/data/reset, each has its own strobe.
module tb_comet_ii_mem_responder;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] adr  = 16'h0000;
  logic        we   = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic        en3 = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  comet_ii_mem_responder_if b0 ();
  comet_ii_mem_responder_if b1 ();
  comet_ii_mem_responder_if b3 ();

  assign b0.adr = adr;  assign b0.we = we;  assign b0.wdata = wdata;  assign b0.adr_en = en0;
  assign b1.adr = adr;  assign b1.we = we;  assign b1.wdata = wdata;  assign b1.adr_en = en1;
  assign b3.adr = adr;  assign b3.we = we;  assign b3.wdata = wdata;  assign b3.adr_en = en3;

  comet_ii_mem_responder #(.ADR_W(12), .WAIT_STATES(0)) u_ws0 (.mclk(mclk), .rst(rst), .bus(b0));
  comet_ii_mem_responder #(.ADR_W(12), .WAIT_STATES(1)) u_ws1 (.mclk(mclk), .rst(rst), .bus(b1));
  comet_ii_mem_responder #(.ADR_W(12), .WAIT_STATES(3)) u_ws3 (.mclk(mclk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_en(input int k, input logic v);
    case (k)
      0:       en0 = v;
      1:       en1 = v;
      default: en3 = v;
    endcase
  endtask

  function automatic logic get_ready(input int k);
    case (k)
      0:       return b0.ready;
      1:       return b1.ready;
      default: return b3.ready;
    endcase
  endfunction

  function automatic logic [15:0] get_rdata(input int k);
    case (k)
      0:       return b0.rdata;
      1:       return b1.rdata;
      default: return b3.rdata;
    endcase
  endfunction

  function automatic logic get_err(input int k);
    case (k)
      0:       return b0.err;
      1:       return b1.err;
      default: return b3.err;
    endcase
  endfunction

  // One transaction on instance k; strobe stays high for 'hold' cycles after
  // the sampling edge. lat = cycle index (1 = cycle after that edge) of ready.
  task automatic xact(input int k, input logic [15:0] a, input logic w,
                      input logic [15:0] d, input int hold,
                      output int lat, output logic [15:0] rd, output logic er);
    @(negedge mclk);
    adr = a; we = w; wdata = d;
    set_en(k, 1'b1);
    @(posedge mclk);
    lat = 0; rd = 16'h0000; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge mclk);
      if (c > hold) set_en(k, 1'b0);
      if (get_ready(k)) begin
        lat = c; rd = get_rdata(k); er = get_err(k);
        break;
      end
    end
    set_en(k, 1'b0);
    if (lat == 0) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge mclk);
    chk("ready_one_shot", 32'(get_ready(k)), 32'd0);
  endtask

  int          lat;
  logic [15:0] rd;
  logic        er;
  int          seen;

  initial begin
    // Reset values
    repeat (3) @(negedge mclk);
    chk("rst_rdata", 32'(b1.rdata), 32'h0000);
    chk("rst_ready", 32'(b1.ready), 32'd0);
    chk("rst_busy",  32'(b1.busy),  32'd0);
    chk("rst_err",   32'(b1.err),   32'd0);
    rst = 1'b0;

    // WS=1 write then read back
    xact(1, 16'h0010, 1'b1, 16'hBEEF, 0, lat, rd, er);
    chk("ws1_wr_lat", 32'(lat), 32'd2);
    chk("ws1_wr_echo", 32'(rd), 32'hBEEF);
    chk("ws1_wr_err", 32'(er), 32'd0);
    xact(1, 16'h0010, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("ws1_rd_lat", 32'(lat), 32'd2);
    chk("ws1_rd_data", 32'(rd), 32'hBEEF);
    xact(1, 16'h0020, 1'b1, 16'h5A5A, 0, lat, rd, er);
    chk("ws1_wr20_echo", 32'(rd), 32'h5A5A);

    // WS=0 preload, then back-to-back reads with strobe held high
    xact(0, 16'h0010, 1'b1, 16'h1111, 0, lat, rd, er);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    xact(0, 16'h0011, 1'b1, 16'h2222, 0, lat, rd, er);
    @(negedge mclk);
    adr = 16'h0010; we = 1'b0; en0 = 1'b1;
    @(negedge mclk);
    chk("b2b_ready1", 32'(b0.ready), 32'd1);
    chk("b2b_rdata1", 32'(b0.rdata), 32'h1111);
    chk("b2b_busy1",  32'(b0.busy),  32'd1);
    adr = 16'h0011;
    @(negedge mclk);
    chk("b2b_gap_ready", 32'(b0.ready), 32'd0);
    chk("b2b_gap_busy",  32'(b0.busy),  32'd0);
    @(negedge mclk);
    chk("b2b_ready2", 32'(b0.ready), 32'd1);
    chk("b2b_rdata2", 32'(b0.rdata), 32'h2222);
    en0 = 1'b0;
    @(negedge mclk);

    // WS=3: strobe held into WAIT then dropped; one pulse after 4 cycles
    xact(3, 16'h0030, 1'b1, 16'hCAFE, 0, lat, rd, er);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    xact(3, 16'h0030, 1'b0, 16'h0000, 2, lat, rd, er);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rd_data", 32'(rd), 32'hCAFE);

    // Reset during WAIT of a write to 0x20 on the WS=1 instance
    @(negedge mclk);
    adr = 16'h0020; we = 1'b1; wdata = 16'hDEAD; en1 = 1'b1;
    @(posedge mclk);
    #1;
    en1 = 1'b0;
    chk("pre_rst_busy", 32'(b1.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy",  32'(b1.busy),  32'd0);
    chk("async_rst_ready", 32'(b1.ready), 32'd0);
    chk("async_rst_rdata", 32'(b1.rdata), 32'h0000);
    @(negedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge mclk);
      if (b1.ready) seen++;
    end
    chk("rst_no_ready", 32'(seen), 32'd0);
    xact(1, 16'h0020, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("rst_wr_dropped", 32'(rd), 32'h5A5A);
    xact(1, 16'h0010, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("mem_survives_rst", 32'(rd), 32'hBEEF);

    // Address above ADR_W
    xact(1, 16'h0005, 1'b1, 16'h7777, 0, lat, rd, er);
    chk("pre_oor_err", 32'(er), 32'd0);
    xact(1, 16'h1005, 1'b1, 16'h1234, 0, lat, rd, er);
`ifdef COMET_II_MEM_BOUNDS_CHECK_EN
    chk("oor_wr_err", 32'(er), 32'd1);
`else
    chk("oor_wr_err", 32'(er), 32'd0);
`endif
    xact(1, 16'h0005, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("low_rd_err", 32'(er), 32'd0);
`ifdef COMET_II_MEM_BOUNDS_CHECK_EN
    chk("low_rd_data", 32'(rd), 32'h7777);
    xact(1, 16'h1005, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_zero", 32'(rd), 32'h0000);
`else
    chk("low_rd_data", 32'(rd), 32'h1234);
    xact(1, 16'h1005, 1'b0, 16'h0000, 0, lat, rd, er);
    chk("wrap_rd_err", 32'(er), 32'd0);
    chk("wrap_rd_data", 32'(rd), 32'h1234);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
